// File: rtl/instr_queue_pkg.sv
// Shared constants for the fetch-to-decode instruction queue.
package instr_queue_pkg;

    localparam int unsigned INSTR_WIDTH   = 32;
    localparam int unsigned DEFAULT_DEPTH = 4;

    // MOV r0,r0: decode substitutes this while out_valid is low
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'hE1A0_0000;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/instr_queue_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port, no reset.
module instr_queue_mem
    import instr_queue_pkg::*;
#(
    parameter int unsigned WIDTH = INSTR_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [ptr_width(DEPTH)-1:0]  wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic [ptr_width(DEPTH)-1:0]  rd_addr,
    output logic [WIDTH-1:0]             rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_fetch_queue.sv
// First-word-fall-through instruction queue between fetch and decode, with single-cycle flush.
// Optional same-cycle empty-queue bypass enabled by defining INSTR_QUEUE_BYPASS_EN.
module instr_fetch_queue
    import instr_queue_pkg::*;
#(
    parameter int unsigned WIDTH = INSTR_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       is_empty,
    output logic                       is_full
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem_rd_data;
    logic             pass_c;
    logic             push_c;
    logic             pop_c;
    logic             wr_en_c;

    assign is_empty = (count == '0);
    assign is_full  = (count == CNT_W'(DEPTH));
    assign in_ready = !is_full;

`ifdef INSTR_QUEUE_BYPASS_EN
    logic bypass_c;

    // Empty queue forwards the incoming word; it is stored only if decode does not take it
    assign bypass_c  = is_empty & in_valid & !flush;
    assign pass_c    = bypass_c & out_ready;
    assign out_valid = !is_empty | bypass_c;
    assign out_data  = bypass_c ? in_data : mem_rd_data;
`else
    assign pass_c    = 1'b0;
    assign out_valid = !is_empty;
    assign out_data  = mem_rd_data;
`endif

    assign push_c  = in_valid & in_ready & !pass_c;
    assign pop_c   = out_valid & out_ready & !pass_c;
    assign wr_en_c = push_c & !flush;

    instr_queue_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en_c),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd_data)
    );

    // Pointers wrap naturally since DEPTH is a power of two; flush overrides any push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
